// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types and default parameters for the pipeline hazard controller.
//   hz_state_e : controller FSM state (idle / waiting on a multi-cycle EX op)
//   hz_ctrl_t  : bundle of pipeline-register control outputs
package hazard_pkg;

  localparam int unsigned DefRegAddrW = 5;
  localparam int unsigned DefMcLat    = 4;
  localparam int unsigned DefCntW     = 32;

  typedef enum logic [0:0] {
    StIdle,
    StMcWait
  } hz_state_e;

  typedef struct packed {
    logic pc_hold;
    logic ifid_hold;
    logic ifid_flush;
    logic idex_hold;
    logic idex_bubble;
    logic idex_flush;
    logic exmem_bubble;
  } hz_ctrl_t;

endpackage

// File: rtl/sat_counter.sv
// sat_counter: W-bit event counter that sticks at all-ones instead of wrapping.
//   clk_i : clock, rising edge
//   rst_i : synchronous active-high clear
//   inc_i : count one event this cycle
//   q_o   : current count
module sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         inc_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (inc_i && (q_q != '1)) begin
      q_d = q_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: drives hold/bubble/flush of the PC and the IF/ID, ID/EX, EX/MEM pipeline
// registers. Handles load-use stalls, taken-branch flushes and multi-cycle EX ops.
//   clk_i, rst_i                      : clock, synchronous active-high reset
//   id_rs1_i/id_rs2_i, id_uses_rs*_i  : source operands of the ID instruction
//   ex_rd_i, ex_mem_read_i            : destination / load flag of the EX instruction
//   ex_mc_start_i, ex_branch_taken_i  : EX op is multi-cycle / EX redirects the PC
//   pc_hold_o .. exmem_bubble_o       : pipeline control, combinational
//   mc_busy_o, mc_done_o              : multi-cycle op in progress / release-cycle pulse
//   perf_stall_cnt_o, perf_flush_cnt_o: saturating counts of pc_hold / ifid_flush cycles
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = DefRegAddrW,
  parameter int unsigned MC_LAT     = DefMcLat,
  parameter int unsigned CNT_W      = DefCntW
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [REG_ADDR_W-1:0] id_rs1_i,
  input  logic [REG_ADDR_W-1:0] id_rs2_i,
  input  logic                  id_uses_rs1_i,
  input  logic                  id_uses_rs2_i,
  input  logic [REG_ADDR_W-1:0] ex_rd_i,
  input  logic                  ex_mem_read_i,
  input  logic                  ex_mc_start_i,
  input  logic                  ex_branch_taken_i,
  output logic                  pc_hold_o,
  output logic                  ifid_hold_o,
  output logic                  ifid_flush_o,
  output logic                  idex_hold_o,
  output logic                  idex_bubble_o,
  output logic                  idex_flush_o,
  output logic                  exmem_bubble_o,
  output logic                  mc_busy_o,
  output logic                  mc_done_o,
  output logic [CNT_W-1:0]      perf_stall_cnt_o,
  output logic [CNT_W-1:0]      perf_flush_cnt_o
);

  localparam int unsigned CntW = $clog2(MC_LAT);
  // The start cycle and the release cycle are not counted by cnt.
  localparam logic [CntW-1:0] CntLoad = CntW'(MC_LAT - 2);

  hz_state_e state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  hz_ctrl_t ctrl;
  logic mc_done;
  logic lu;

  assign lu = ex_mem_read_i && (ex_rd_i != '0) &&
              ((id_uses_rs1_i && (id_rs1_i == ex_rd_i)) ||
               (id_uses_rs2_i && (id_rs2_i == ex_rd_i)));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ctrl    = '0;
    mc_done = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (ex_branch_taken_i) begin
          ctrl.ifid_flush = 1'b1;
          ctrl.idex_flush = 1'b1;
        end else if (ex_mc_start_i) begin
          ctrl.pc_hold      = 1'b1;
          ctrl.ifid_hold    = 1'b1;
          ctrl.idex_hold    = 1'b1;
          ctrl.exmem_bubble = 1'b1;
          cnt_d             = CntLoad;
          state_d           = StMcWait;
        end else if (lu) begin
          ctrl.pc_hold     = 1'b1;
          ctrl.ifid_hold   = 1'b1;
          ctrl.idex_bubble = 1'b1;
        end
      end
      StMcWait: begin
        // ex_mc_start stays high from the held op; it is deliberately ignored here.
        if (cnt_q != '0) begin
          ctrl.pc_hold      = 1'b1;
          ctrl.ifid_hold    = 1'b1;
          ctrl.idex_hold    = 1'b1;
          ctrl.exmem_bubble = 1'b1;
          cnt_d             = cnt_q - 1'b1;
        end else begin
          mc_done = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    if (rst_i) begin
      ctrl    = '0;
      mc_done = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign pc_hold_o      = ctrl.pc_hold;
  assign ifid_hold_o    = ctrl.ifid_hold;
  assign ifid_flush_o   = ctrl.ifid_flush;
  assign idex_hold_o    = ctrl.idex_hold;
  assign idex_bubble_o  = ctrl.idex_bubble;
  assign idex_flush_o   = ctrl.idex_flush;
  assign exmem_bubble_o = ctrl.exmem_bubble;
  assign mc_busy_o      = (state_q == StMcWait) && !rst_i;
  assign mc_done_o      = mc_done;

  sat_counter #(
    .W(CNT_W)
  ) u_stall_cnt (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .inc_i(ctrl.pc_hold),
    .q_o  (perf_stall_cnt_o)
  );

  sat_counter #(
    .W(CNT_W)
  ) u_flush_cnt (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .inc_i(ctrl.ifid_flush),
    .q_o  (perf_flush_cnt_o)
  );

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller that drives the hold/bubble/flush inputs of the PC and the IF/ID, ID/EX and EX/MEM pipeline registers. It detects load-use hazards, taken branches resolved in EX, and multi-cycle EX operations (mul/div). It sequences multi-cycle stalls with a small FSM and keeps saturating stall and flush performance counters. It sits beside the datapath and is the control-side counterpart of the pipeline registers, which only consume these signals.

## Interface
- REG_ADDR_W, 5, register index width
- MC_LAT, 4, cycles a multi-cycle op occupies EX (must be >= 2)
- CNT_W, 32, performance counter width

- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-high
- id_rs1, id_rs2  in  REG_ADDR_W  source registers of the instruction in ID
- id_uses_rs1, id_uses_rs2  in  1  the ID instruction reads rs1 / rs2
- ex_rd  in  REG_ADDR_W  destination register of the EX instruction
- ex_mem_read  in  1  the EX instruction is a load
- ex_mc_start  in  1  the EX instruction is multi-cycle
- ex_branch_taken  in  1  the EX branch/jump redirects the PC
- pc_hold  out  1  PC keeps its value
- ifid_hold, ifid_flush  out  1  IF/ID hold / clear
- idex_hold, idex_bubble, idex_flush  out  1  ID/EX hold / insert NOP / clear
- exmem_bubble  out  1  EX/MEM inserts a NOP
- mc_busy  out  1  FSM is in MC_WAIT
- mc_done  out  1  one-cycle pulse on the release cycle of a multi-cycle op
- perf_stall_cnt, perf_flush_cnt  out  CNT_W  saturating event counters

## Operation
- FSM states: IDLE, MC_WAIT. Down-counter cnt is clog2(MC_LAT) bits wide.
- Load-use condition (lu): ex_mem_read, ex_rd != 0, and ((id_uses_rs1 and id_rs1 == ex_rd) or (id_uses_rs2 and id_rs2 == ex_rd)).
- IDLE, priority order:
  - ex_branch_taken: ifid_flush = idex_flush = 1. Overrides lu.
  - ex_mc_start: pc_hold = ifid_hold = idex_hold = exmem_bubble = 1. Load cnt = MC_LAT-2. Next state MC_WAIT.
  - lu: pc_hold = ifid_hold = idex_bubble = 1.
  - Otherwise all control outputs are 0.
- MC_WAIT:
  - cnt != 0: assert the same four hold/bubble outputs as mc start, then decrement cnt.
  - cnt == 0: all control outputs are 0, mc_done = 1, next state IDLE.
  - ex_mc_start, ex_branch_taken and lu are ignored in MC_WAIT. The held mc instruction keeps ex_mc_start high and must not retrigger.
- mc_busy = (state == MC_WAIT).
- perf_stall_cnt increments on every cycle with pc_hold = 1. perf_flush_cnt increments on every cycle with ifid_flush = 1. Both counters saturate at all-ones and never wrap.

## Timing
- All control outputs and mc_done are combinational from the current state and inputs, valid in the same cycle. State, cnt and the counters update on the rising edge of clk.
- A multi-cycle op entering EX at cycle T holds the front end for cycles T..T+MC_LAT-2. Cycle T+MC_LAT-1 is the release cycle (mc_done = 1). The next instruction is in EX at T+MC_LAT.
- MC_LAT = 2: MC_WAIT lasts one cycle, the release cycle.
- A load-use stall lasts exactly one cycle. At the next cycle the load is in MEM and lu is false.
- rst high: next state is IDLE, cnt = 0, both counters = 0. While rst is high, every control output, mc_busy and mc_done is forced to 0. Reset asserted in MC_WAIT aborts the op with no mc_done pulse.

## Structure
- hazard_pkg: state enum (IDLE, MC_WAIT), default REG_ADDR_W, MC_LAT and CNT_W.
- One sub-module, sat_counter (parameter W; inputs clk, rst, inc; output q). It is instantiated twice, once per performance counter.

## Test plan
- Load-use: ex_mem_read = 1, ex_rd = 5, id_rs2 = 5, id_uses_rs2 = 1 -> pc_hold = ifid_hold = idex_bubble = 1 for one cycle; perf_stall_cnt goes 0 -> 1. Same stimulus with ex_rd = 0 -> no stall.
- Branch plus load-use in the same cycle -> ifid_flush = idex_flush = 1 and pc_hold = 0; perf_flush_cnt = 1.
- MC_LAT = 4, ex_mc_start held high for 4 cycles from T -> holds asserted at T, T+1, T+2; release with mc_done = 1 at T+3; back in IDLE at T+4; perf_stall_cnt = 3. No retrigger.
- rst pulsed at T+1 of a multi-cycle op -> at T+2 state is IDLE, all outputs 0, counters 0, no mc_done.
- CNT_W = 4, 20 load-use events -> perf_stall_cnt stops at 15.
